mem_access_unit: RTL and testbench

Load/store initiator between the pipeline's memory stage and the data memory. It accepts one load or store request at a time over a valid/ready handshake and checks alignment. It drives the data memory port with a word-aligned address, and leaves unwritten byte lanes at high impedance so the memory keeps them unchanged. For loads it extracts the requested byte or halfword lane and sign- or zero-extends it to 32 bits.

---
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit.sv | 123 ++++++++++++
 tb/tb_mem_access_unit.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - clock edge selector package and request/memory bus interface
package ClockEdge;
  typedef enum logic {Rising, Falling} edge_e;
endpackage

interface mem_access_unit_if #(
  parameter int AddrWidth = 7
);
  logic                 reqValid;
  logic                 reqReady;
  logic                 reqWrite;
  logic [1:0]           reqSize;
  logic                 reqSigned;
  logic [AddrWidth-1:0] reqAddr;
  logic [31:0]          reqData;
  logic                 respValid;
  logic [31:0]          respData;
  logic                 respError;
  logic                 memEnable;
  logic                 memWrite;
  logic [AddrWidth-1:0] memAddr;
  logic [31:0]          memWData;
  logic [31:0]          memRData;

  modport master (
    input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData, memRData,
    output reqReady, respValid, respData, respError, memEnable, memWrite, memAddr, memWData
  );
  modport slave (
    output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData, memRData,
    input  reqReady, respValid, respData, respError, memEnable, memWrite, memAddr, memWData
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator with alignment check, lane masking and load extension
module mem_access_unit #(
  parameter int               AddrWidth = 7,
  parameter ClockEdge::edge_e Edge      = ClockEdge::Rising
) (
  input logic               clock,
  input logic               reset,
  mem_access_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e               r_state, w_next;
  logic                 w_clk;
  logic                 r_write, r_signed, r_err;
  logic [1:0]           r_size;
  logic [AddrWidth-1:0] r_addr;
  logic [31:0]          r_data, r_resp_data;
  logic                 w_req_err;
  logic [15:0]          w_shift;
  logic [31:0]          w_load_ext, w_wdata;
  logic [3:0]           w_lane_en;

  assign w_clk = (Edge == ClockEdge::Rising) ? clock : ~clock;

  always_comb begin
    w_req_err = 1'b0;
    unique case (bus.reqSize)
      2'd0:    w_req_err = 1'b0;
      2'd1:    w_req_err = bus.reqAddr[0];
      2'd2:    w_req_err = |bus.reqAddr[1:0];
      default: w_req_err = 1'b1;
    endcase
  end

  // Halfword loads are halfword aligned, so the byte-lane shift also selects the right half.
  always_comb begin
    w_shift = 16'(bus.memRData >> {r_addr[1:0], 3'b000});
    unique case (r_size)
      2'd0:    w_load_ext = {{24{r_signed & w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_load_ext = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
      default: w_load_ext = bus.memRData;
    endcase
  end

  // Store data is replicated across lanes; the lane enables pick which copies reach the bus.
  always_comb begin
    w_lane_en = 4'b0000;
    w_wdata   = r_data;
    if (r_state == ACCESS && r_write) begin
      unique case (r_size)
        2'd0: begin
          w_lane_en = 4'b0001 << r_addr[1:0];
          w_wdata   = {4{r_data[7:0]}};
        end
        2'd1: begin
          w_lane_en = r_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata   = {2{r_data[15:0]}};
        end
        default: w_lane_en = 4'b1111;
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign bus.memWData[8*k +: 8] = w_lane_en[k] ? w_wdata[8*k +: 8] : 8'hzz;
  end

  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_signed    <= 1'b0;
      r_err       <= 1'b0;
      r_size      <= 2'd0;
      r_addr      <= '0;
      r_data      <= '0;
      r_resp_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.reqValid) begin
        r_write     <= bus.reqWrite;
        r_signed    <= bus.reqSigned;
        r_size      <= bus.reqSize;
        r_addr      <= bus.reqAddr;
        r_data      <= bus.reqData;
        r_err       <= w_req_err;
        r_resp_data <= '0;
      end else if (r_state == ACCESS && !r_write) begin
        r_resp_data <= w_load_ext;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.reqReady  = 1'b0;
    bus.respValid = 1'b0;
    bus.respError = 1'b0;
    bus.respData  = '0;
    bus.memEnable = 1'b0;
    bus.memWrite  = 1'b0;
    bus.memAddr   = '0;
    unique case (r_state)
      IDLE: begin
        bus.reqReady = !reset;
        if (bus.reqValid) w_next = w_req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.memEnable = 1'b1;
        bus.memWrite  = r_write;
        bus.memAddr   = {r_addr[AddrWidth-1:2], 2'b00};
        w_next        = RESP;
      end
      RESP: begin
        bus.respValid = 1'b1;
        bus.respError = r_err;
        bus.respData  = r_resp_data;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit with byte-array reference model
module tb_mem_access_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_access_unit_if #(.AddrWidth(7)) bus ();

  mem_access_unit #(.AddrWidth(7), .Edge(ClockEdge::Rising)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] phys [0:31] = '{default: 32'h0};
  logic [3:0]  cur_mask = 4'h0;
  int          en_cnt = 0;

  assign bus.memRData = phys[bus.memAddr[6:2]];

  always @(posedge clock) begin
    if (bus.memEnable && bus.memWrite)
      for (int k = 0; k < 4; k++)
        if (cur_mask[k]) phys[bus.memAddr[6:2]][8*k +: 8] <= bus.memWData[8*k +: 8];
    if (bus.memEnable) en_cnt <= en_cnt + 1;
  end

  logic [7:0] mdl [0:127] = '{default: 8'h0};
  int n_cmp = 0;
  int n_fail = 0;

  bit          ob_timeout, ob_en1, ob_we1, ob_rv1, ob_re1, ob_rv2, ob_re2, ob_rdy2, ob_rdy3;
  logic [6:0]  ob_addr1;
  logic [31:0] ob_wd1, ob_rd1, ob_rd2;

  task automatic model_apply(input bit w, input logic [1:0] sz, input bit sg, input logic [6:0] a,
                             input logic [31:0] d, output logic [31:0] ed, output bit ee,
                             output logic [31:0] ewd);
    int n;
    int lane;
    longint v;
    n    = 1 << sz;
    lane = int'(a) % 4;
    v    = 0;
    ed   = '0;
    ewd  = 32'hzzzz_zzzz;
    ee   = (sz == 2'd3) || (int'(a) % n != 0);
    if (!ee) begin
      if (w) begin
        for (int i = 0; i < n; i++) begin
          mdl[int'(a) + i] = d[8*i +: 8];
          ewd[8*(lane + i) +: 8] = d[8*i +: 8];
        end
      end else begin
        for (int i = 0; i < n; i++) v += longint'(mdl[int'(a) + i]) << (8*i);
        if (sg && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
        ed = v[31:0];
      end
    end
  endtask

  task automatic run_req(input bit w, input logic [1:0] sz, input bit sg, input logic [6:0] a,
                         input logic [31:0] d);
    int n;
    @(negedge clock);
    bus.reqValid  = 1'b1;
    bus.reqWrite  = w;
    bus.reqSize   = sz;
    bus.reqSigned = sg;
    bus.reqAddr   = a;
    bus.reqData   = d;
    cur_mask = (sz == 2'd0) ? (4'b0001 << a[1:0]) : (sz == 2'd1) ? (a[1] ? 4'b1100 : 4'b0011) : 4'hF;
    n = 0;
    while (!bus.reqReady && n < 10) begin
      @(negedge clock);
      n++;
    end
    ob_timeout = !bus.reqReady;
    @(negedge clock);
    bus.reqValid = 1'b0;
    ob_en1 = bus.memEnable;  ob_we1 = bus.memWrite;  ob_addr1 = bus.memAddr;  ob_wd1 = bus.memWData;
    ob_rv1 = bus.respValid;  ob_re1 = bus.respError; ob_rd1 = bus.respData;
    @(negedge clock);
    ob_rv2 = bus.respValid;  ob_re2 = bus.respError; ob_rd2 = bus.respData;  ob_rdy2 = bus.reqReady;
    @(negedge clock);
    ob_rdy3 = bus.reqReady;
  endtask

  task automatic test_reset();
    logic [31:0] zz;
    zz = 32'hzzzz_zzzz;
    @(negedge clock);
    n_cmp++; if (bus.reqReady !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.reqReady); end
    n_cmp++; if ({bus.respValid, bus.respError, bus.memEnable, bus.memWrite} !== 4'b0) begin
      n_fail++; $display("FAIL rst_flags: got %b want 0000", {bus.respValid, bus.respError, bus.memEnable, bus.memWrite}); end
    n_cmp++; if (bus.respData !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.respData); end
    n_cmp++; if (bus.memAddr !== 7'h0) begin n_fail++; $display("FAIL rst_maddr: got %h want 0", bus.memAddr); end
    n_cmp++; if (bus.memWData !== zz) begin n_fail++; $display("FAIL rst_wdata: got %h want %h", bus.memWData, zz); end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (bus.reqReady !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", bus.reqReady); end
  endtask

  task automatic test_word_store_load();
    logic [31:0] ed, ewd;
    bit ee;
    model_apply(1, 2'd2, 0, 7'h08, 32'hDEADBEEF, ed, ee, ewd);
    run_req(1, 2'd2, 0, 7'h08, 32'hDEADBEEF);
    n_cmp++; if ({ob_timeout, ob_en1, ob_we1} !== 3'b011) begin n_fail++; $display("FAIL wsl_st_access: got %b want 011", {ob_timeout, ob_en1, ob_we1}); end
    n_cmp++; if (ob_addr1 !== 7'h08) begin n_fail++; $display("FAIL wsl_st_addr: got %h want 08", ob_addr1); end
    n_cmp++; if (ob_wd1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wsl_st_wdata: got %h want deadbeef", ob_wd1); end
    n_cmp++; if ({ob_rv1, ob_rv2, ob_re2, ob_rdy2, ob_rdy3} !== 5'b01001) begin
      n_fail++; $display("FAIL wsl_st_timing: got %b want 01001", {ob_rv1, ob_rv2, ob_re2, ob_rdy2, ob_rdy3}); end
    n_cmp++; if (ob_rd2 !== 32'h0) begin n_fail++; $display("FAIL wsl_st_rdata: got %h want 0", ob_rd2); end
    model_apply(0, 2'd2, 0, 7'h08, 32'h0, ed, ee, ewd);
    run_req(0, 2'd2, 0, 7'h08, 32'h0);
    n_cmp++; if ({ob_en1, ob_we1, ob_rv2, ob_re2} !== 4'b1010) begin n_fail++; $display("FAIL wsl_ld_flags: got %b want 1010", {ob_en1, ob_we1, ob_rv2, ob_re2}); end
    n_cmp++; if (ob_wd1 !== ewd) begin n_fail++; $display("FAIL wsl_ld_wdata: got %h want %h", ob_wd1, ewd); end
    n_cmp++; if (ob_rd2 !== 32'hDEADBEEF || ob_rd2 !== ed) begin n_fail++; $display("FAIL wsl_ld_rdata: got %h want deadbeef", ob_rd2); end
  endtask

  task automatic test_byte_mask();
    logic [31:0] ed, ewd, want;
    bit ee;
    want = {8'hzz, 8'hAA, 16'hzzzz};
    model_apply(1, 2'd2, 0, 7'h10, 32'h11223344, ed, ee, ewd);
    run_req(1, 2'd2, 0, 7'h10, 32'h11223344);
    model_apply(1, 2'd0, 0, 7'h12, 32'hFFFFFFAA, ed, ee, ewd);
    run_req(1, 2'd0, 0, 7'h12, 32'hFFFFFFAA);
    n_cmp++; if (ob_wd1 !== want) begin n_fail++; $display("FAIL bm_wdata: got %h want %h", ob_wd1, want); end
    n_cmp++; if (ob_addr1 !== 7'h10) begin n_fail++; $display("FAIL bm_addr: got %h want 10", ob_addr1); end
    model_apply(0, 2'd2, 0, 7'h10, 32'h0, ed, ee, ewd);
    run_req(0, 2'd2, 0, 7'h10, 32'h0);
    n_cmp++; if (ob_rd2 !== 32'h11AA3344 || ob_rd2 !== ed) begin n_fail++; $display("FAIL bm_load: got %h want 11aa3344", ob_rd2); end
  endtask

  task automatic test_extension();
    logic [31:0] ed, ewd;
    bit ee;
    logic [1:0]  t_sz [4] = '{2'd0, 2'd0, 2'd1, 2'd0};
    bit          t_sg [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [6:0]  t_a  [4] = '{7'h22, 7'h22, 7'h22, 7'h20};
    logic [31:0] t_x  [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00000001};
    model_apply(1, 2'd2, 0, 7'h20, 32'h80FF7F01, ed, ee, ewd);
    run_req(1, 2'd2, 0, 7'h20, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      run_req(0, t_sz[i], t_sg[i], t_a[i], 32'h0);
      n_cmp++; if (ob_rd2 !== t_x[i] || ob_re2 !== 1'b0) begin
        n_fail++; $display("FAIL ext_%0d: got %h err %b want %h err 0", i, ob_rd2, ob_re2, t_x[i]); end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] ed, ewd;
    bit ee;
    int en0;
    bit          t_w  [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  t_sz [3] = '{2'd1, 2'd2, 2'd3};
    logic [6:0]  t_a  [3] = '{7'h05, 7'h0E, 7'h00};
    en0 = en_cnt;
    for (int i = 0; i < 3; i++) begin
      model_apply(t_w[i], t_sz[i], 0, t_a[i], 32'hCAFEF00D, ed, ee, ewd);
      run_req(t_w[i], t_sz[i], 0, t_a[i], 32'hCAFEF00D);
      n_cmp++; if ({ob_timeout, ob_rv1, ob_re1, ob_en1, ob_rv2, ob_rdy2} !== 6'b011001) begin
        n_fail++; $display("FAIL mis_%0d_timing: got %b want 011001", i, {ob_timeout, ob_rv1, ob_re1, ob_en1, ob_rv2, ob_rdy2}); end
      n_cmp++; if (ob_rd1 !== 32'h0) begin n_fail++; $display("FAIL mis_%0d_rdata: got %h want 0", i, ob_rd1); end
    end
    n_cmp++; if (en_cnt != en0) begin n_fail++; $display("FAIL mis_no_access: got %0d enables want 0", en_cnt - en0); end
    model_apply(0, 2'd2, 0, 7'h0C, 32'h0, ed, ee, ewd);
    run_req(0, 2'd2, 0, 7'h0C, 32'h0);
    n_cmp++; if (ob_rd2 !== ed) begin n_fail++; $display("FAIL mis_mem_unchanged: got %h want %h", ob_rd2, ed); end
  endtask

  task automatic test_handshake();
    logic [6:0]  addrs [3] = '{7'h08, 7'h10, 7'h20};
    logic [31:0] exp [3];
    logic [31:0] got [3];
    logic [31:0] ewd;
    bit ee, acc;
    int idx, pulses, bad;
    int acc_cyc [3];
    for (int i = 0; i < 3; i++) model_apply(0, 2'd2, 0, addrs[i], 32'h0, exp[i], ee, ewd);
    idx = 0; pulses = 0; bad = 0;
    acc_cyc = '{-1, -1, -1};
    got = '{0, 0, 0};
    @(negedge clock);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqSize = 2'd2; bus.reqSigned = 1'b0; bus.reqAddr = addrs[0];
    for (int c = 0; c < 16; c++) begin
      if ((bus.memEnable || bus.respValid) && bus.reqReady) bad++;
      if (bus.respValid) begin
        if (pulses < 3) got[pulses] = bus.respData;
        pulses++;
      end
      acc = bus.reqReady && bus.reqValid;
      if (acc && idx < 3) acc_cyc[idx] = c;
      @(posedge clock);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) bus.reqAddr = addrs[idx];
        else bus.reqValid = 1'b0;
      end
      @(negedge clock);
    end
    bus.reqValid = 1'b0;
    n_cmp++; if (idx != 3) begin n_fail++; $display("FAIL hs_accepts: got %0d want 3", idx); end
    n_cmp++; if (acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
      n_fail++; $display("FAIL hs_spacing: got %0d,%0d,%0d want gaps of 3", acc_cyc[0], acc_cyc[1], acc_cyc[2]); end
    n_cmp++; if (pulses != 3) begin n_fail++; $display("FAIL hs_pulses: got %0d want 3", pulses); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL hs_ready_busy: got %0d busy-ready cycles want 0", bad); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL hs_data_%0d: got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed, ewd, zz;
    bit ee;
    int pulses;
    zz = 32'hzzzz_zzzz;
    pulses = 0;
    @(negedge clock);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqSize = 2'd2; bus.reqSigned = 1'b0; bus.reqAddr = 7'h20;
    @(negedge clock);
    bus.reqValid = 1'b0;
    n_cmp++; if (bus.memEnable !== 1'b1) begin n_fail++; $display("FAIL rm_in_access: got %b want 1", bus.memEnable); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({bus.reqReady, bus.respValid, bus.respError, bus.memEnable, bus.memWrite} !== 5'b0) begin
      n_fail++; $display("FAIL rm_flags: got %b want 00000", {bus.reqReady, bus.respValid, bus.respError, bus.memEnable, bus.memWrite}); end
    n_cmp++; if (bus.memAddr !== 7'h0 || bus.respData !== 32'h0 || bus.memWData !== zz) begin
      n_fail++; $display("FAIL rm_buses: got addr %h rdata %h wdata %h want 0 0 z", bus.memAddr, bus.respData, bus.memWData); end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (bus.respValid) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL rm_no_resp: got %0d pulses want 0", pulses); end
    n_cmp++; if (bus.reqReady !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after: got %b want 1", bus.reqReady); end
    model_apply(0, 2'd2, 0, 7'h20, 32'h0, ed, ee, ewd);
    run_req(0, 2'd2, 0, 7'h20, 32'h0);
    n_cmp++; if (ob_rd2 !== ed || ob_rv2 !== 1'b1) begin n_fail++; $display("FAIL rm_reload: got %h valid %b want %h valid 1", ob_rd2, ob_rv2, ed); end
  endtask

  task automatic test_random();
    logic [31:0] ed, ewd, d;
    logic [6:0]  a;
    logic [1:0]  sz;
    bit ee, w, sg;
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 7'($urandom_range(0, 127));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~7'((1 << sz) - 1);
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      d  = $urandom;
      if (i % 2 == 1 && !ee && w == 1'b0) begin
        sz = 2'($urandom_range(0, 2));
        a  = a & ~7'((1 << sz) - 1);
      end
      model_apply(w, sz, sg, a, d, ed, ee, ewd);
      run_req(w, sz, sg, a, d);
      n_cmp++; if (ob_timeout) begin n_fail++; $display("FAIL rnd_%0d_timeout: got no accept want accept", i); end
      if (ee) begin
        n_cmp++; if ({ob_rv1, ob_re1, ob_en1, ob_rd1} !== {3'b110, 32'h0}) begin
          n_fail++; $display("FAIL rnd_%0d_err: got rv %b err %b en %b data %h want 1 1 0 0", i, ob_rv1, ob_re1, ob_en1, ob_rd1); end
      end else begin
        n_cmp++; if ({ob_rv1, ob_en1, ob_we1, ob_rv2, ob_re2} !== {2'b01, w, 2'b10}) begin
          n_fail++; $display("FAIL rnd_%0d_flow: got %b want %b", i, {ob_rv1, ob_en1, ob_we1, ob_rv2, ob_re2}, {2'b01, w, 2'b10}); end
        n_cmp++; if (ob_rd2 !== ed) begin n_fail++; $display("FAIL rnd_%0d_rdata: got %h want %h", i, ob_rd2, ed); end
        n_cmp++; if (ob_wd1 !== ewd || ob_addr1 !== {a[6:2], 2'b00}) begin
          n_fail++; $display("FAIL rnd_%0d_bus: got %h@%h want %h@%h", i, ob_wd1, ob_addr1, ewd, {a[6:2], 2'b00}); end
      end
      if (w && !ee) begin
        model_apply(0, sz, sg, a, 32'h0, ed, ee, ewd);
        run_req(0, sz, sg, a, 32'h0);
        n_cmp++; if (ob_rd2 !== ed) begin n_fail++; $display("FAIL rnd_%0d_b2b: got %h want %h", i, ob_rd2, ed); end
      end
    end
  endtask

  initial begin
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqSize = 2'd0; bus.reqSigned = 1'b0;
    bus.reqAddr = 7'h0;  bus.reqData = 32'h0;
    test_reset();
    test_word_store_load();
    test_byte_mask();
    test_extension();
    test_misalign();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
